// File: rtl/serial_slice_alu.sv
// Multi-cycle ALU: one SLICE-bit group per clock, carry chained LSB to MSB.
// start/busy/done handshake; SLT, zero and overflow flags come out registered.
module serial_slice_alu #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
      $error("serial_slice_alu: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] a_s, b_s, bb, slice_res;
  logic [SLICE:0]   sum_w;
  logic             c_out, c_in_msb, sum_msb, ovf_w, is_arith;

  always_comb begin
    a_s      = a_q[k_q*SLICE +: SLICE];
    b_s      = b_q[k_q*SLICE +: SLICE];
    bb       = op_q[2] ? ~b_s : b_s;
    sum_w    = {1'b0, a_s} + {1'b0, bb} + {{SLICE{1'b0}}, carry_q};
    sum_msb  = sum_w[SLICE-1];
    c_out    = sum_w[SLICE];
    // carry into the MSB recovered from the MSB sum bit
    c_in_msb = a_s[SLICE-1] ^ bb[SLICE-1] ^ sum_msb;
    ovf_w    = c_in_msb ^ c_out;
    is_arith = op_q[1];
    unique case (op_q[1:0])
      2'b00:   slice_res = a_s & bb;
      2'b01:   slice_res = a_s | bb;
      default: slice_res = sum_w[SLICE-1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = op[2];
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d[k_q*SLICE +: SLICE] = slice_res;
        carry_d = c_out;
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          cout_d = is_arith & c_out;
          ovf_d  = is_arith & ovf_w;
          if (op_q[1:0] == 2'b11) begin
            result_d    = '0;
            result_d[0] = sum_msb ^ ovf_w;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        zero_d  = (result_q == '0);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      carry_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_slice_alu.sv
// Directed bench for serial_slice_alu at 16/4, 8/4 and 32/8 widths.
// Inputs driven and outputs sampled on the falling edge.
module tb_serial_slice_alu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start16 = 0, busy16, done16, cout16, ovf16, zero16;
  logic [2:0]  op16 = 0;
  logic [15:0] a16 = 0, b16 = 0, res16;

  logic        start8 = 0, busy8, done8, cout8, ovf8, zero8;
  logic [2:0]  op8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, res8;

  logic        start32 = 0, busy32, done32, cout32, ovf32, zero32;
  logic [2:0]  op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, res32;

  serial_slice_alu #(.WIDTH(16), .SLICE(4)) u16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16),
    .a(a16), .b(b16), .busy(busy16), .done(done16),
    .result(res16), .cout(cout16), .overflow(ovf16), .zero(zero16)
  );

  serial_slice_alu #(.WIDTH(8), .SLICE(4)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .result(res8), .cout(cout8), .overflow(ovf8), .zero(zero8)
  );

  serial_slice_alu #(.WIDTH(32), .SLICE(8)) u32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32),
    .a(a32), .b(b32), .busy(busy32), .done(done32),
    .result(res32), .cout(cout32), .overflow(ovf32), .zero(zero32)
  );

  // Issue one 16-bit op; return the cycle done was seen (0 = never) and busy count.
  task automatic do16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                      output int lat, output int bcnt);
    @(negedge clk);
    start16 = 1; op16 = o; a16 = x; b16 = y;
    @(negedge clk);
    start16 = 0;
    lat = 0; bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy16) bcnt++;
      if (done16) begin lat = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    checks++; if ({busy16, done16, cout16, ovf16, zero16} !== 5'b0) begin errors++;
      $display("FAIL reset_flags16 got %b exp 00000", {busy16, done16, cout16, ovf16, zero16}); end
    checks++; if (res16 !== 16'h0) begin errors++; $display("FAIL reset_res16 got %h exp 0000", res16); end
    checks++; if (res8 !== 8'h0 || busy8 !== 1'b0) begin errors++; $display("FAIL reset_8 got %h/%b exp 00/0", res8, busy8); end
    checks++; if (res32 !== 32'h0 || done32 !== 1'b0) begin errors++; $display("FAIL reset_32 got %h/%b exp 0/0", res32, done32); end
    reset = 0;
  endtask

  task automatic test_add;
    int lat, bcnt;
    do16(3'b010, 16'h7FFF, 16'h0001, lat, bcnt);
    checks++; if (lat != 6) begin errors++; $display("FAIL add_latency got %0d exp 6", lat); end
    checks++; if (bcnt != 4) begin errors++; $display("FAIL add_busy got %0d exp 4", bcnt); end
    checks++; if (res16 !== 16'h8000) begin errors++; $display("FAIL add_res got %h exp 8000", res16); end
    checks++; if ({cout16, ovf16, zero16} !== 3'b010) begin errors++;
      $display("FAIL add_flags got %b exp 010", {cout16, ovf16, zero16}); end
    @(negedge clk);
    checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b exp 0", done16); end
    checks++; if (res16 !== 16'h8000) begin errors++; $display("FAIL add_hold got %h exp 8000", res16); end
  endtask

  task automatic test_sub;
    int lat, bcnt;
    do16(3'b110, 16'h0005, 16'h0005, lat, bcnt);
    checks++; if (res16 !== 16'h0000) begin errors++; $display("FAIL sub0_res got %h exp 0000", res16); end
    checks++; if ({cout16, ovf16, zero16} !== 3'b101) begin errors++;
      $display("FAIL sub0_flags got %b exp 101", {cout16, ovf16, zero16}); end
    do16(3'b110, 16'h8000, 16'h0001, lat, bcnt);
    checks++; if (res16 !== 16'h7FFF) begin errors++; $display("FAIL subov_res got %h exp 7fff", res16); end
    checks++; if ({cout16, ovf16, zero16} !== 3'b110) begin errors++;
      $display("FAIL subov_flags got %b exp 110", {cout16, ovf16, zero16}); end
  endtask

  task automatic test_slt;
    int lat, bcnt;
    do16(3'b111, 16'h8000, 16'h0001, lat, bcnt);
    checks++; if (res16 !== 16'h0001) begin errors++; $display("FAIL slt_ovf_res got %h exp 0001", res16); end
    checks++; if ({cout16, ovf16, zero16} !== 3'b110) begin errors++;
      $display("FAIL slt_ovf_flags got %b exp 110", {cout16, ovf16, zero16}); end
    do16(3'b111, 16'h0003, 16'h0007, lat, bcnt);
    checks++; if (res16 !== 16'h0001 || zero16 !== 1'b0) begin errors++;
      $display("FAIL slt_lt got %h/%b exp 0001/0", res16, zero16); end
    do16(3'b111, 16'h0007, 16'h0003, lat, bcnt);
    checks++; if (res16 !== 16'h0000 || zero16 !== 1'b1) begin errors++;
      $display("FAIL slt_ge got %h/%b exp 0000/1", res16, zero16); end
  endtask

  task automatic test_logic;
    int lat, bcnt;
    do16(3'b000, 16'hF0F0, 16'h3C3C, lat, bcnt);
    checks++; if (res16 !== 16'h3030) begin errors++; $display("FAIL and_res got %h exp 3030", res16); end
    checks++; if ({cout16, ovf16, zero16} !== 3'b000) begin errors++;
      $display("FAIL and_flags got %b exp 000", {cout16, ovf16, zero16}); end
    do16(3'b001, 16'hF0F0, 16'h3C3C, lat, bcnt);
    checks++; if (res16 !== 16'hFCFC) begin errors++; $display("FAIL or_res got %h exp fcfc", res16); end
    do16(3'b100, 16'hF0F0, 16'h3C3C, lat, bcnt);
    checks++; if (res16 !== 16'hC0C0) begin errors++; $display("FAIL andn_res got %h exp c0c0", res16); end
    checks++; if ({cout16, ovf16} !== 2'b00) begin errors++;
      $display("FAIL andn_flags got %b exp 00", {cout16, ovf16}); end
  endtask

  task automatic test_back_to_back;
    int ndone;
    logic [15:0] exp_r;
    ndone = 0;
    for (int n = 0; n <= 18; n++) begin
      @(negedge clk);
      if (n > 0) begin
        checks++; if (done16 !== ((n % 6) == 0)) begin errors++;
          $display("FAIL b2b_done n=%0d got %b exp %b", n, done16, (n % 6) == 0); end
        if (done16) begin
          ndone++;
          exp_r = 16'h0110 + 16'(n - 6);
          checks++; if (res16 !== exp_r) begin errors++;
            $display("FAIL b2b_res n=%0d got %h exp %h", n, res16, exp_r); end
        end
      end
      if (n < 18) begin
        start16 = 1; op16 = 3'b010; a16 = 16'h0100 + 16'(n); b16 = 16'h0010;
      end else begin
        start16 = 0;
      end
    end
    checks++; if (ndone != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", ndone); end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clk);
    start16 = 1; op16 = 3'b010; a16 = 16'h1234; b16 = 16'h1111;
    @(negedge clk);
    start16 = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++; if ({busy16, done16, cout16, ovf16, zero16} !== 5'b0 || res16 !== 16'h0) begin errors++;
      $display("FAIL abort_outputs got %b/%h exp 00000/0000", {busy16, done16, cout16, ovf16, zero16}, res16); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done16 || busy16) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", seen); end
  endtask

  task automatic test_w8;
    int lat;
    @(negedge clk);
    start8 = 1; op8 = 3'b010; a8 = 8'hFF; b8 = 8'h01;
    @(negedge clk);
    start8 = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done8) begin lat = i; break; end
      @(negedge clk);
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL w8_latency got %0d exp 4", lat); end
    checks++; if (res8 !== 8'h00) begin errors++; $display("FAIL w8_res got %h exp 00", res8); end
    checks++; if ({cout8, ovf8, zero8} !== 3'b101) begin errors++;
      $display("FAIL w8_flags got %b exp 101", {cout8, ovf8, zero8}); end
  endtask

  task automatic test_w32;
    int lat;
    @(negedge clk);
    start32 = 1; op32 = 3'b110; a32 = 32'h0; b32 = 32'h1;
    @(negedge clk);
    start32 = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done32) begin lat = i; break; end
      @(negedge clk);
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL w32_latency got %0d exp 6", lat); end
    checks++; if (res32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL w32_res got %h exp ffffffff", res32); end
    checks++; if ({cout32, ovf32, zero32} !== 3'b000) begin errors++;
      $display("FAIL w32_flags got %b exp 000", {cout32, ovf32, zero32}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_back_to_back();
    test_reset_abort();
    test_w8();
    test_w32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
